// File: rtl/pc_unit_param_if.sv
// Bus between the control/ALU side and the program-counter unit.
// The master drives next-PC selection and trap control; the slave returns the PC state.
interface pc_unit_param_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [1:0]      next_sel;
    logic            branch_taken;
    logic [XLEN-1:0] branch_off;
    logic [25:0]     jump_idx;
    logic [XLEN-1:0] jr_addr;
    logic            exc_req;
    logic            trap_ack;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic            in_trap;
    logic            misaligned;
    logic [31:0]     instr_count;

    modport master (
        output stall, next_sel, branch_taken, branch_off, jump_idx, jr_addr, exc_req, trap_ack,
        input  pc, pc_plus_step, in_trap, misaligned, instr_count
    );

    modport slave (
        input  stall, next_sel, branch_taken, branch_off, jump_idx, jr_addr, exc_req, trap_ack,
        output pc, pc_plus_step, in_trap, misaligned, instr_count
    );
endinterface

// File: rtl/pc_unit_param.sv
// Program-counter unit: PC register, PC+STEP adder and next-PC select,
// with a RUN/TRAP state machine entered on misaligned targets or exception requests.
//
// state | meaning
// RUN   | PC advances each unstalled cycle to the selected target
// TRAP  | PC parked at EXC_VEC until trap_ack
module pc_unit_param #(
    parameter int              XLEN      = 32,
    parameter int              STEP      = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0080)
) (
    input  logic           clk,
    input  logic           rst,
    pc_unit_param_if.slave bus
);
    localparam int              SHIFT      = $clog2(STEP);
    localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
    // Bits replaced by the J-type index; above them the upper pc_plus_step bits are kept.
    localparam logic [XLEN-1:0] JMP_MASK   = (XLEN > 28) ? XLEN'(32'h0FFF_FFFF) : {XLEN{1'b1}};

    typedef enum logic {
        ST_RUN,
        ST_TRAP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] pc_plus_step;
    logic [XLEN-1:0] jmp_field;
    logic [XLEN-1:0] target;

    assign pc_plus_step = pc_q + STEP_V;
    assign jmp_field    = XLEN'({bus.jump_idx, 2'b00});

    always_comb begin
        target = pc_plus_step;
        case (bus.next_sel)
            2'd1: if (bus.branch_taken) target = pc_plus_step + (bus.branch_off << SHIFT);
            2'd2: target = (pc_plus_step & ~JMP_MASK) | (jmp_field & JMP_MASK);
            2'd3: target = bus.jr_addr;
            default: target = pc_plus_step;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        count_d      = count_q;
        case (state_q)
            ST_RUN: begin
                if (bus.exc_req) begin
                    pc_d    = EXC_VEC;
                    state_d = ST_TRAP;
                end else if (!bus.stall) begin
                    if ((target & ALIGN_MASK) != '0) begin
                        misaligned_d = 1'b1;
                        pc_d         = EXC_VEC;
                        state_d      = ST_TRAP;
                    end else begin
                        pc_d = target;
                        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                    end
                end
            end
            ST_TRAP: begin
                pc_d = EXC_VEC;
                if (bus.trap_ack) state_d = ST_RUN;
            end
            default: begin
                pc_d    = EXC_VEC;
                state_d = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VEC;
            misaligned_q <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus_step = pc_plus_step;
    assign bus.in_trap      = (state_q == ST_TRAP);
    assign bus.misaligned   = misaligned_q;
    assign bus.instr_count  = count_q;
endmodule

// File: tb/tb_pc_unit_param.sv
// Directed bench for pc_unit_param: sequential, branch, jump, jump-register,
// misaligned trap, stall, exception, wrap-around and count saturation.
module tb_pc_unit_param;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pc_unit_param_if #(.XLEN(32)) bus ();

    pc_unit_param #(
        .XLEN(32),
        .STEP(4),
        .RESET_VEC(32'h0000_0000),
        .EXC_VEC(32'h0000_0080)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.stall        = 1'b0;
        bus.next_sel     = 2'd0;
        bus.branch_taken = 1'b0;
        bus.branch_off   = 32'h0;
        bus.jump_idx     = 26'h0;
        bus.jr_addr      = 32'h0;
        bus.exc_req      = 1'b0;
        bus.trap_ack     = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] addr);
        set_idle();
        bus.next_sel = 2'd3;
        bus.jr_addr  = addr;
        tick();
        set_idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0);
        end
        n_cmp++;
        if (bus.in_trap !== 1'b0 || bus.misaligned !== 1'b0 || bus.instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_flags: got trap=%b mis=%b cnt=%0d want 0/0/0",
                     bus.in_trap, bus.misaligned, bus.instr_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            n_cmp++;
            if (bus.pc !== exp_pc) begin
                n_err++;
                $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_pc);
            end
        end
        n_cmp++;
        if (bus.instr_count !== 32'd3) begin
            n_err++;
            $display("FAIL seq_count: got %0d want 3", bus.instr_count);
        end
    endtask

    task automatic test_branch();
        load_pc(32'h0000_0010);
        bus.next_sel     = 2'd1;
        bus.branch_taken = 1'b1;
        bus.branch_off   = 32'hFFFF_FFFE;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h0000_000C) begin
            n_err++;
            $display("FAIL branch_taken: got %h want %h", bus.pc, 32'h0000_000C);
        end
        load_pc(32'h0000_0010);
        bus.next_sel     = 2'd1;
        bus.branch_taken = 1'b0;
        bus.branch_off   = 32'hFFFF_FFFE;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h0000_0014) begin
            n_err++;
            $display("FAIL branch_not_taken: got %h want %h", bus.pc, 32'h0000_0014);
        end
        set_idle();
        n_cmp++;
        if (bus.instr_count !== 32'd7) begin
            n_err++;
            $display("FAIL branch_count: got %0d want 7", bus.instr_count);
        end
    endtask

    task automatic test_jump();
        load_pc(32'h1000_0004);
        bus.next_sel = 2'd2;
        bus.jump_idx = 26'h10;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h1000_0040) begin
            n_err++;
            $display("FAIL jump: got %h want %h", bus.pc, 32'h1000_0040);
        end
        load_pc(32'h0000_0200);
        n_cmp++;
        if (bus.pc !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL jump_reg: got %h want %h", bus.pc, 32'h0000_0200);
        end
        n_cmp++;
        if (bus.instr_count !== 32'd10) begin
            n_err++;
            $display("FAIL jump_count: got %0d want 10", bus.instr_count);
        end
    endtask

    task automatic test_trap_misaligned();
        bus.next_sel = 2'd3;
        bus.jr_addr  = 32'h0000_0202;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h80 || bus.in_trap !== 1'b1 || bus.misaligned !== 1'b1) begin
            n_err++;
            $display("FAIL misaligned_entry: got pc=%h trap=%b mis=%b want 80/1/1",
                     bus.pc, bus.in_trap, bus.misaligned);
        end
        n_cmp++;
        if (bus.instr_count !== 32'd10) begin
            n_err++;
            $display("FAIL misaligned_count: got %0d want 10", bus.instr_count);
        end
        bus.jr_addr = 32'h0000_0300;
        bus.exc_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h80 || bus.in_trap !== 1'b1) begin
            n_err++;
            $display("FAIL trap_hold: got pc=%h trap=%b want 80/1", bus.pc, bus.in_trap);
        end
        bus.trap_ack = 1'b1;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h80 || bus.in_trap !== 1'b0) begin
            n_err++;
            $display("FAIL trap_ack: got pc=%h trap=%b want 80/0", bus.pc, bus.in_trap);
        end
        set_idle();
        tick();
        n_cmp++;
        if (bus.pc !== 32'h84 || bus.instr_count !== 32'd11 || bus.misaligned !== 1'b1) begin
            n_err++;
            $display("FAIL resume: got pc=%h cnt=%0d mis=%b want 84/11/1",
                     bus.pc, bus.instr_count, bus.misaligned);
        end
    endtask

    task automatic test_stall();
        bus.stall    = 1'b1;
        bus.next_sel = 2'd3;
        bus.jr_addr  = 32'h0000_0400;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.pc !== 32'h84 || bus.instr_count !== 32'd11) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d want 84/11",
                         i, bus.pc, bus.instr_count);
            end
        end
        n_cmp++;
        if (bus.pc_plus_step !== 32'h88) begin
            n_err++;
            $display("FAIL pc_plus_step: got %h want %h", bus.pc_plus_step, 32'h88);
        end
        bus.exc_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.pc !== 32'h80 || bus.in_trap !== 1'b1 || bus.instr_count !== 32'd11) begin
            n_err++;
            $display("FAIL stall_exc: got pc=%h trap=%b cnt=%0d want 80/1/11",
                     bus.pc, bus.in_trap, bus.instr_count);
        end
        set_idle();
        bus.trap_ack = 1'b1;
        tick();
        set_idle();
    endtask

    task automatic test_wrap_saturate();
        load_pc(32'hFFFF_FFFC);
        n_cmp++;
        if (bus.pc_plus_step !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_plus_step: got %h want %h", bus.pc_plus_step, 32'h0);
        end
        tick();
        n_cmp++;
        if (bus.pc !== 32'h0 || bus.instr_count !== 32'd13) begin
            n_err++;
            $display("FAIL wrap_pc: got pc=%h cnt=%0d want 0/13", bus.pc, bus.instr_count);
        end
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        tick();
        n_cmp++;
        if (bus.instr_count !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL sat_first: got %h want %h", bus.instr_count, 32'hFFFF_FFFF);
        end
        tick();
        n_cmp++;
        if (bus.instr_count !== 32'hFFFF_FFFF || bus.pc !== 32'h8) begin
            n_err++;
            $display("FAIL sat_hold: got cnt=%h pc=%h want ffffffff/8", bus.instr_count, bus.pc);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.misaligned !== 1'b0 || bus.instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL final_reset: got mis=%b cnt=%h want 0/0", bus.misaligned, bus.instr_count);
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        set_idle();
        test_reset();
        test_branch();
        test_jump();
        test_trap_misaligned();
        test_stall();
        test_wrap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
